// File: rtl/aes0_ct_capture.sv
// Ciphertext capture stage for the AES-192 core: start-pulse generation, ct_valid wait
// with timeout, result capture with plaintext-scrub request, and a gated 32-bit read port.
module aes0_ct_capture #(
    parameter int CT_WIDTH       = 128,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [CT_WIDTH-1:0] ct_i,
    input  logic                ct_valid_i,
    input  logic                debug_mode_i,
    input  logic                rd_lock_i,
    input  logic                rd_en_i,
    input  logic [1:0]          rd_idx_i,
    output logic [31:0]         rd_data_o,
    output logic                start_pulse_o,
    output logic                clr_pc_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                timeout_o
);

    typedef enum logic [2:0] {ST_IDLE, ST_ARM, ST_WAIT, ST_DONE, ST_ERR} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              start_q;
    logic              clr_pc_q;
    logic [3:0][31:0]  result_q;
    logic              rise;
    logic              capture;

    assign rise = start_i & ~start_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: if (rise) state_d = ST_ARM;
            ST_ARM: begin
                count_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // valid on the last counted cycle still wins over the timeout
                if (ct_valid_i) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (count_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_ERR;
                end else begin
                    count_d = count_q + 1'b1;
                end
            end
            ST_DONE: if (rise) state_d = ST_ARM;
            ST_ERR:  if (rise) state_d = ST_ARM;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            start_q  <= 1'b0;
            clr_pc_q <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            start_q  <= start_i;
            clr_pc_q <= capture;
            // debug mode scrubs the result on every clock, including a capture edge
            if (debug_mode_i)  result_q <= '0;
            else if (capture)  result_q <= ct_i;
        end
    end

    assign start_pulse_o = (state_q == ST_ARM);
    assign busy_o        = (state_q == ST_ARM) || (state_q == ST_WAIT);
    assign done_o        = (state_q == ST_DONE);
    assign timeout_o     = (state_q == ST_ERR);
    assign clr_pc_o      = clr_pc_q;

    assign rd_data_o = (rd_en_i && !rd_lock_i && !debug_mode_i && state_q == ST_DONE)
                       ? result_q[rd_idx_i] : 32'h0;

endmodule

// File: tb/tb_aes0_ct_capture.sv
// Directed bench: instance "a" uses the default timeout (64), instance "b" uses 4;
// both share the same inputs.
module tb_aes0_ct_capture;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         start_i;
    logic [127:0] ct_i;
    logic         ct_valid_i;
    logic         debug_mode_i;
    logic         rd_lock_i;
    logic         rd_en_i;
    logic [1:0]   rd_idx_i;

    logic [31:0]  rd_a, rd_b;
    logic         sp_a, sp_b, clr_a, clr_b, busy_a, busy_b, done_a, done_b, to_a, to_b;

    int checks = 0;
    int failures = 0;

    localparam logic [127:0] CT1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    localparam logic [127:0] CT2 = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    localparam logic [127:0] CT3 = 128'h13579BDF_2468ACE0_0F0F0F0F_F0F0F0F0;

    always #5 clk_i = ~clk_i;

    aes0_ct_capture dut_a (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ct_i(ct_i),
        .ct_valid_i(ct_valid_i), .debug_mode_i(debug_mode_i), .rd_lock_i(rd_lock_i),
        .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_a),
        .start_pulse_o(sp_a), .clr_pc_o(clr_a), .busy_o(busy_a),
        .done_o(done_a), .timeout_o(to_a)
    );

    aes0_ct_capture #(.TIMEOUT_CYCLES(4)) dut_b (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ct_i(ct_i),
        .ct_valid_i(ct_valid_i), .debug_mode_i(debug_mode_i), .rd_lock_i(rd_lock_i),
        .rd_en_i(rd_en_i), .rd_idx_i(rd_idx_i), .rd_data_o(rd_b),
        .start_pulse_o(sp_b), .clr_pc_o(clr_b), .busy_o(busy_b),
        .done_o(done_b), .timeout_o(to_b)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] flags;
        rst_ni = 1'b0; start_i = 1'b0; ct_i = '0; ct_valid_i = 1'b0;
        debug_mode_i = 1'b0; rd_lock_i = 1'b0; rd_en_i = 1'b1; rd_idx_i = 2'd0;
        tick(); tick();
        flags = {sp_a, clr_a, busy_a, done_a, to_a, sp_b | clr_b | busy_b | done_b | to_b};
        checks++;
        if (flags !== 6'b0) begin
            failures++; $display("FAIL reset_outputs got=%b want=000000", flags);
        end
        checks++;
        if (rd_a !== 32'h0) begin
            failures++; $display("FAIL reset_read got=%h want=00000000", rd_a);
        end
        rst_ni = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0) begin
            failures++; $display("FAIL reset_release_idle busy got=%b want=0", busy_a);
        end
    endtask

    task automatic test_valid_idle();
        ct_i = CT2; ct_valid_i = 1'b1;
        tick(); tick();
        ct_valid_i = 1'b0;
        checks++;
        if ({done_a, busy_a, clr_a} !== 3'b000) begin
            failures++; $display("FAIL valid_in_idle done/busy/clr got=%b want=000", {done_a, busy_a, clr_a});
        end
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [4];
        exp_w[0] = 32'hCCDDEEFF; exp_w[1] = 32'h8899AABB;
        exp_w[2] = 32'h44556677; exp_w[3] = 32'h00112233;
        start_i = 1'b1;
        tick();
        checks++;
        if ({sp_a, busy_a} !== 2'b11) begin
            failures++; $display("FAIL basic_arm sp/busy got=%b want=11", {sp_a, busy_a});
        end
        tick();
        checks++;
        if ({sp_a, busy_a} !== 2'b01) begin
            failures++; $display("FAIL basic_pulse_width sp/busy got=%b want=01", {sp_a, busy_a});
        end
        repeat (4) tick();
        checks++;
        if (done_a !== 1'b0) begin
            failures++; $display("FAIL basic_early_done got=%b want=0", done_a);
        end
        ct_i = CT1; ct_valid_i = 1'b1;
        tick();
        ct_valid_i = 1'b0; ct_i = '0;
        checks++;
        if ({done_a, clr_a, busy_a} !== 3'b110) begin
            failures++; $display("FAIL basic_done done/clr/busy got=%b want=110", {done_a, clr_a, busy_a});
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx_i = 2'(i);
            #1;
            checks++;
            if (rd_a !== exp_w[i]) begin
                failures++; $display("FAIL basic_read idx=%0d got=%h want=%h", i, rd_a, exp_w[i]);
            end
        end
        tick();
        checks++;
        if ({done_a, clr_a} !== 2'b10) begin
            failures++; $display("FAIL basic_clr_width done/clr got=%b want=10", {done_a, clr_a});
        end
    endtask

    task automatic test_timeout();
        start_i = 1'b0; tick();
        start_i = 1'b1; tick();
        checks++;
        if (sp_b !== 1'b1) begin
            failures++; $display("FAIL timeout_arm sp got=%b want=1", sp_b);
        end
        repeat (4) tick();
        checks++;
        if ({busy_b, to_b} !== 2'b10) begin
            failures++; $display("FAIL timeout_wait4 busy/to got=%b want=10", {busy_b, to_b});
        end
        tick();
        checks++;
        if ({to_b, busy_b, done_b} !== 3'b100) begin
            failures++; $display("FAIL timeout_err to/busy/done got=%b want=100", {to_b, busy_b, done_b});
        end
        for (int i = 0; i < 4; i++) begin
            rd_idx_i = 2'(i);
            #1;
            checks++;
            if (rd_b !== 32'h0) begin
                failures++; $display("FAIL timeout_read idx=%0d got=%h want=00000000", i, rd_b);
            end
        end
    endtask

    task automatic test_back_to_back();
        // dut_a is still in WAIT here; its rise must be dropped while dut_b re-arms
        start_i = 1'b0; tick();
        start_i = 1'b1; tick();
        checks++;
        if ({sp_b, sp_a, busy_a} !== 3'b101) begin
            failures++; $display("FAIL b2b_rise sp_b/sp_a/busy_a got=%b want=101", {sp_b, sp_a, busy_a});
        end
        tick();
        ct_i = CT2; ct_valid_i = 1'b1;
        tick();
        ct_valid_i = 1'b0; ct_i = '0;
        rd_idx_i = 2'd1;
        #1;
        checks++;
        if ({done_b, clr_b, to_b} !== 3'b110) begin
            failures++; $display("FAIL recover_done done/clr/to got=%b want=110", {done_b, clr_b, to_b});
        end
        checks++;
        if (rd_b !== 32'h89ABCDEF) begin
            failures++; $display("FAIL recover_read got=%h want=89abcdef", rd_b);
        end
        checks++;
        if (rd_a !== 32'h89ABCDEF) begin
            failures++; $display("FAIL b2b_read_a got=%h want=89abcdef", rd_a);
        end
    endtask

    task automatic test_race();
        start_i = 1'b0; tick();
        start_i = 1'b1; tick();
        repeat (4) tick();
        checks++;
        if ({busy_b, to_b} !== 2'b10) begin
            failures++; $display("FAIL race_wait4 busy/to got=%b want=10", {busy_b, to_b});
        end
        ct_i = CT3; ct_valid_i = 1'b1;
        tick();
        ct_valid_i = 1'b0; ct_i = '0;
        checks++;
        if ({done_b, to_b} !== 2'b10) begin
            failures++; $display("FAIL race_done done/to got=%b want=10", {done_b, to_b});
        end
        rd_idx_i = 2'd3; #1;
        checks++;
        if (rd_b !== 32'h13579BDF) begin
            failures++; $display("FAIL race_read3 got=%h want=13579bdf", rd_b);
        end
        rd_idx_i = 2'd0; #1;
        checks++;
        if (rd_b !== 32'hF0F0F0F0) begin
            failures++; $display("FAIL race_read0 got=%h want=f0f0f0f0", rd_b);
        end
    endtask

    task automatic test_lock_debug();
        rd_idx_i = 2'd3; rd_lock_i = 1'b1; #1;
        checks++;
        if (rd_b !== 32'h0) begin
            failures++; $display("FAIL lock_read got=%h want=00000000", rd_b);
        end
        rd_lock_i = 1'b0; #1;
        checks++;
        if (rd_b !== 32'h13579BDF) begin
            failures++; $display("FAIL unlock_read got=%h want=13579bdf", rd_b);
        end
        debug_mode_i = 1'b1; #1;
        checks++;
        if (rd_b !== 32'h0) begin
            failures++; $display("FAIL debug_gate got=%h want=00000000", rd_b);
        end
        tick();
        debug_mode_i = 1'b0; #1;
        checks++;
        if ({done_b, rd_b} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL debug_scrub done=%b rd=%h want done=1 rd=00000000", done_b, rd_b);
        end
        start_i = 1'b0; tick();
        start_i = 1'b1; tick();
        tick();
        debug_mode_i = 1'b1; ct_i = CT2; ct_valid_i = 1'b1;
        tick();
        debug_mode_i = 1'b0; ct_valid_i = 1'b0; ct_i = '0;
        rd_idx_i = 2'd1; #1;
        checks++;
        if ({done_b, rd_b} !== {1'b1, 32'h0}) begin
            failures++; $display("FAIL debug_capture done=%b rd=%h want done=1 rd=00000000", done_b, rd_b);
        end
    endtask

    task automatic test_async_reset();
        start_i = 1'b0; tick();
        start_i = 1'b1; tick();
        tick();
        checks++;
        if (busy_b !== 1'b1) begin
            failures++; $display("FAIL areset_pre busy got=%b want=1", busy_b);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({busy_a, busy_b, done_a, done_b, to_b} !== 5'b0) begin
            failures++; $display("FAIL areset_mid_wait flags got=%b want=00000", {busy_a, busy_b, done_a, done_b, to_b});
        end
        start_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_valid_idle();
        test_basic();
        test_timeout();
        test_back_to_back();
        test_race();
        test_lock_debug();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
